// File: rtl/alert_handler_esc_timer_gen_if.sv
// alert_handler_esc_timer_gen_if: configuration, trigger and escalation signals of one class timer
interface alert_handler_esc_timer_gen_if #(
    parameter int NPhases = 4,
    parameter int NEscSev = 4,
    parameter int CntDw   = 32
);
    localparam int PhIdxW = $clog2(NPhases);
    logic                       en_i;
    logic                       clr_i;
    logic                       clr_lock_i;
    logic                       timeout_en_i;
    logic                       accu_trig_i;
    logic                       accu_fail_i;
    logic [CntDw-1:0]           timeout_cyc_i;
    logic [NPhases*CntDw-1:0]   phase_cyc_i;
    logic [NEscSev-1:0]         esc_en_i;
    logic [NEscSev*PhIdxW-1:0]  esc_map_i;
    logic                       esc_trig_o;
    logic [CntDw-1:0]           esc_cnt_o;
    logic [2:0]                 esc_state_o;
    logic [PhIdxW-1:0]          esc_phase_o;
    logic                       locked_o;
    logic [NEscSev-1:0]         esc_sig_req_o;
    modport master (
        output en_i, clr_i, clr_lock_i, timeout_en_i, accu_trig_i, accu_fail_i,
               timeout_cyc_i, phase_cyc_i, esc_en_i, esc_map_i,
        input  esc_trig_o, esc_cnt_o, esc_state_o, esc_phase_o, locked_o, esc_sig_req_o
    );
    modport slave (
        input  en_i, clr_i, clr_lock_i, timeout_en_i, accu_trig_i, accu_fail_i,
               timeout_cyc_i, phase_cyc_i, esc_en_i, esc_map_i,
        output esc_trig_o, esc_cnt_o, esc_state_o, esc_phase_o, locked_o, esc_sig_req_o
    );
endinterface

// File: rtl/alert_handler_esc_timer_gen.sv
// alert_handler_esc_timer_gen: parametrised per-class interrupt timeout and phased escalation timer
module alert_handler_esc_timer_gen #(
    parameter int NPhases = 4,
    parameter int NEscSev = 4,
    parameter int CntDw   = 32
) (
    input logic clk_i,
    input logic rst_i,
    alert_handler_esc_timer_gen_if.slave bus
);
    localparam int PhIdxW = $clog2(NPhases);
    localparam logic [PhIdxW-1:0] LastPh = PhIdxW'(NPhases - 1);
    // sparse encoding: every undefined pattern is caught by the default branch
    typedef enum logic [5:0] {
        IDLE     = 6'b001010,
        TIMEOUT  = 6'b100101,
        PHASE    = 6'b010011,
        TERMINAL = 6'b111000,
        FSMERR   = 6'b001111
    } state_e;
    state_e             state_q;
    logic [CntDw-1:0]   cnt_q;
    logic [CntDw-1:0]   cnt_inc;
    logic [CntDw-1:0]   ph_thr;
    logic [PhIdxW-1:0]  phase_q;
    logic               trig_q;
    logic               locked_q;
    logic               esc_act;
    logic [NEscSev-1:0] req;
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CntDw'(1);
    assign ph_thr  = bus.phase_cyc_i[int'(phase_q)*CntDw +: CntDw];
    // state, counter, phase index, trigger pulse and clear lock
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            phase_q  <= '0;
            trig_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            if (bus.accu_fail_i) begin
                state_q <= FSMERR;
                cnt_q   <= '0;
                phase_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.en_i && bus.accu_trig_i) begin
                            state_q <= PHASE;
                            cnt_q   <= '0;
                            phase_q <= '0;
                            trig_q  <= 1'b1;
                        end else if (bus.en_i && bus.timeout_en_i && |bus.timeout_cyc_i) begin
                            state_q <= TIMEOUT;
                            cnt_q   <= '0;
                        end
                    end
                    TIMEOUT: begin
                        if (bus.accu_trig_i || cnt_q >= bus.timeout_cyc_i - CntDw'(1)) begin
                            state_q <= PHASE;
                            cnt_q   <= '0;
                            phase_q <= '0;
                            trig_q  <= 1'b1;
                        end else if (!bus.timeout_en_i || bus.clr_i) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    PHASE: begin
                        if (bus.clr_i && !locked_q) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            phase_q <= '0;
                        end else if (cnt_q >= ph_thr) begin
                            cnt_q <= '0;
                            if (phase_q == LastPh) begin
                                state_q  <= TERMINAL;
                                locked_q <= bus.clr_lock_i;
                            end else begin
                                phase_q <= phase_q + PhIdxW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                    TERMINAL: begin
                        if (bus.clr_i && !locked_q) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            phase_q <= '0;
                        end
                    end
                    FSMERR: begin
                        state_q <= FSMERR;
                    end
                    default: begin
                        state_q <= FSMERR;
                        cnt_q   <= '0;
                        phase_q <= '0;
                    end
                endcase
            end
        end
    end
    // per-signal request: enabled signal whose mapped phase is the active one
    always_comb begin
        req = '0;
        for (int s = 0; s < NEscSev; s++) begin
            req[s] = bus.esc_en_i[s] && esc_act && (bus.esc_map_i[s*PhIdxW +: PhIdxW] == phase_q);
        end
    end
    assign esc_act = (state_q == PHASE) || (state_q == TERMINAL);
    assign bus.esc_state_o = (state_q == IDLE)     ? 3'd0 :
                             (state_q == TIMEOUT)  ? 3'd1 :
                             (state_q == PHASE)    ? 3'd2 :
                             (state_q == TERMINAL) ? 3'd3 : 3'd7;
    assign bus.esc_sig_req_o = (bus.esc_state_o == 3'd7) ? '1 : req;
    assign bus.esc_trig_o    = trig_q;
    assign bus.esc_cnt_o     = cnt_q;
    assign bus.esc_phase_o   = phase_q;
    assign bus.locked_o      = locked_q;
endmodule

// File: tb/tb_alert_handler_esc_timer_gen.sv
// tb_alert_handler_esc_timer_gen: directed and randomized checks against a phase-schedule model
module tb_alert_handler_esc_timer_gen;
    localparam int NP = 4;
    localparam int NS = 4;
    localparam int CW = 16;
    localparam int PW = $clog2(NP);
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int c[NP];
    int m[NS];
    logic [NS-1:0] en_v;
    always #5 clk = ~clk;
    alert_handler_esc_timer_gen_if #(.NPhases(NP), .NEscSev(NS), .CntDw(CW)) bus ();
    alert_handler_esc_timer_gen #(.NPhases(NP), .NEscSev(NS), .CntDw(CW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus.slave)
    );
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag, input int st, input int cnt, input int ph,
                           input int trig, input int lk, input logic [NS-1:0] sig);
        chk({tag, ".state"}, 32'(bus.esc_state_o), st);
        chk({tag, ".cnt"}, 32'(bus.esc_cnt_o), cnt);
        chk({tag, ".phase"}, 32'(bus.esc_phase_o), ph);
        chk({tag, ".trig"}, 32'(bus.esc_trig_o), trig);
        chk({tag, ".locked"}, 32'(bus.locked_o), lk);
        chk({tag, ".sig"}, 32'(bus.esc_sig_req_o), 32'(sig));
    endtask
    task automatic cfg;
        for (int k = 0; k < NP; k++) bus.phase_cyc_i[k*CW +: CW] = CW'(c[k]);
        for (int s = 0; s < NS; s++) bus.esc_map_i[s*PW +: PW] = PW'(m[s]);
        bus.esc_en_i = en_v;
    endtask
    function automatic logic [NS-1:0] exp_sig(input int ph);
        logic [NS-1:0] r;
        for (int s = 0; s < NS; s++) r[s] = en_v[s] && (m[s] == ph);
        return r;
    endfunction
    // called on the first sampled cycle of phase 0; walks the cumulative phase schedule
    task automatic run_esc(input string tag, input bit lock, input int extra);
        int total;
        int start;
        int k;
        int hi[NS];
        total = 0;
        for (int j = 0; j < NP; j++) total += c[j] + 1;
        for (int s = 0; s < NS; s++) hi[s] = 0;
        for (int i = 0; i < total + extra; i++) begin
            if (i < total) begin
                start = 0;
                k = 0;
                while (i >= start + c[k] + 1) begin
                    start += c[k] + 1;
                    k++;
                end
                chk_all(tag, 2, i - start, k, (i == 0) ? 1 : 0, 0, exp_sig(k));
                for (int s = 0; s < NS; s++) hi[s] += int'(bus.esc_sig_req_o[s]);
            end else begin
                chk_all({tag, ".term"}, 3, 0, NP - 1, 0, lock, exp_sig(NP - 1));
            end
            tick;
        end
        for (int s = 0; s < NS; s++) chk({tag, ".sig_len"}, hi[s], en_v[s] ? c[m[s]] + 1 : 0);
    endtask
    task automatic clear_to_idle(input string tag);
        bus.clr_i = 1'b1;
        tick;
        bus.clr_i = 1'b0;
        chk_all(tag, 0, 0, 0, 0, 0, '0);
    endtask
    initial begin
        int n;
        int t;
        bus.en_i = 1'b0;
        bus.clr_i = 1'b0;
        bus.clr_lock_i = 1'b0;
        bus.timeout_en_i = 1'b0;
        bus.accu_trig_i = 1'b0;
        bus.accu_fail_i = 1'b0;
        bus.timeout_cyc_i = '0;
        bus.phase_cyc_i = '0;
        bus.esc_en_i = '0;
        bus.esc_map_i = '0;
        #23 rst = 1'b0;
        #1 chk_all("reset", 0, 0, 0, 0, 0, '0);
        tick;
        chk_all("idle", 0, 0, 0, 0, 0, '0);
        c = '{2, 3, 0, 1};
        m = '{0, 1, 2, 3};
        en_v = 4'hF;
        cfg;
        bus.en_i = 1'b1;
        bus.accu_trig_i = 1'b1;
        tick;
        bus.accu_trig_i = 1'b0;
        run_esc("esc", 1'b0, 3);
        clear_to_idle("clr_term");
        bus.timeout_cyc_i = CW'(5);
        bus.timeout_en_i = 1'b1;
        tick;
        chk_all("tmo_enter", 1, 0, 0, 0, 0, '0);
        for (int i = 1; i < 5; i++) begin
            tick;
            chk_all("tmo_count", 1, i, 0, 0, 0, '0);
        end
        tick;
        chk_all("tmo_fire", 2, 0, 0, 1, 0, exp_sig(0));
        bus.timeout_en_i = 1'b0;
        repeat (3) tick;
        chk_all("ph1", 2, 0, 1, 0, 0, exp_sig(1));
        clear_to_idle("clr_ph1");
        bus.timeout_en_i = 1'b1;
        tick;
        repeat (3) tick;
        chk_all("tmo_cnt3", 1, 3, 0, 0, 0, '0);
        bus.timeout_en_i = 1'b0;
        tick;
        chk_all("tmo_abort", 0, 0, 0, 0, 0, '0);
        repeat (2) tick;
        chk_all("tmo_abort_hold", 0, 0, 0, 0, 0, '0);
        repeat (3) begin
            t = $urandom_range(1, 9);
            bus.timeout_cyc_i = CW'(t);
            bus.timeout_en_i = 1'b1;
            tick;
            n = 0;
            while (bus.esc_state_o != 3'd2 && n < 50) begin
                tick;
                n++;
            end
            chk("tmo_rand_len", n, t);
            chk("tmo_rand_trig", 32'(bus.esc_trig_o), 1);
            bus.timeout_en_i = 1'b0;
            clear_to_idle("tmo_rand_clr");
        end
        bus.timeout_cyc_i = CW'(20);
        bus.timeout_en_i = 1'b1;
        tick;
        tick;
        bus.accu_trig_i = 1'b1;
        bus.clr_i = 1'b1;
        tick;
        bus.accu_trig_i = 1'b0;
        bus.clr_i = 1'b0;
        bus.timeout_en_i = 1'b0;
        chk_all("trig_clr", 2, 0, 0, 1, 0, exp_sig(0));
        clear_to_idle("trig_clr_idle");
        bus.en_i = 1'b0;
        bus.accu_trig_i = 1'b1;
        tick;
        bus.accu_trig_i = 1'b0;
        chk_all("en_off", 0, 0, 0, 0, 0, '0);
        tick;
        chk_all("en_off_hold", 0, 0, 0, 0, 0, '0);
        bus.en_i = 1'b1;
        repeat (4) begin
            for (int k = 0; k < NP; k++) c[k] = $urandom_range(0, 4);
            for (int s = 0; s < NS; s++) m[s] = $urandom_range(0, NP - 1);
            en_v = NS'($urandom);
            cfg;
            bus.accu_trig_i = 1'b1;
            tick;
            bus.accu_trig_i = 1'b0;
            run_esc("rand", 1'b0, 2);
            clear_to_idle("rand_clr");
        end
        bus.clr_lock_i = 1'b1;
        bus.accu_trig_i = 1'b1;
        tick;
        bus.accu_trig_i = 1'b0;
        run_esc("lock", 1'b1, 2);
        bus.clr_i = 1'b1;
        repeat (3) begin
            tick;
            chk_all("lock_clr", 3, 0, NP - 1, 0, 1, exp_sig(NP - 1));
        end
        bus.clr_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 chk_all("lock_rst", 0, 0, 0, 0, 0, '0);
        bus.clr_lock_i = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        chk_all("lock_rst_idle", 0, 0, 0, 0, 0, '0);
        en_v = '0;
        cfg;
        bus.accu_fail_i = 1'b1;
        tick;
        bus.accu_fail_i = 1'b0;
        chk_all("fsm_err", 7, 0, 0, 0, 0, '1);
        bus.clr_i = 1'b1;
        tick;
        tick;
        bus.clr_i = 1'b0;
        chk_all("fsm_err_clr", 7, 0, 0, 0, 0, '1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0, 0, '0);
        #2 rst = 1'b0;
        tick;
        chk_all("post_rst", 0, 0, 0, 0, 0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alert_handler_esc_timer_gen.md
Name: alert_handler_esc_timer_gen

Overview:
Parametrised escalation timer for one alert class, succeeding the fixed 4-phase/4-signal class timer. It has configurable phase count, escalation-signal count and counter width, and adds a terminal clear-lock and a fatal FSM-error state. One instance sits per class between the class accumulator and the escalation senders. Its escalation requests are OR-reduced per severity across classes.

Parameters:
NPhases, 4, number of escalation phases (>=2)
NEscSev, 4, number of escalation signals driven
CntDw, 32, width of timeout/phase counter and cycle thresholds
PhIdxW, $clog2(NPhases), derived; width of a phase index (localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  class enable; gates only entry from Idle
clr_i  in  1  class clear pulse
clr_lock_i  in  1  when high, Terminal entry makes clear ineffective until reset
timeout_en_i  in  1  class interrupt pending; starts the interrupt timeout
accu_trig_i  in  1  accumulator threshold crossed
accu_fail_i  in  1  accumulator integrity failure
timeout_cyc_i  in  CntDw  interrupt timeout in cycles; 0 = timeout disabled
phase_cyc_i  in  NPhases*CntDw  per-phase duration thresholds; phase k at [k*CntDw +: CntDw]
esc_en_i  in  NEscSev  per-signal escalation enable
esc_map_i  in  NEscSev*PhIdxW  phase that fires signal s, at [s*PhIdxW +: PhIdxW]
esc_trig_o  out  1  one-cycle pulse on entry to phase 0
esc_cnt_o  out  CntDw  current counter value
esc_state_o  out  3  Idle=0, Timeout=1, Phase=2, Terminal=3, FsmError=7
esc_phase_o  out  PhIdxW  current phase index; 0 outside Phase, NPhases-1 in Terminal
locked_o  out  1  clear lock active
esc_sig_req_o  out  NEscSev  escalation requests to senders

Behaviour:
- Reset: state Idle, cnt 0, phase 0, locked_o 0. All outputs 0.
- Idle:
  - If en_i & accu_trig_i, go to Phase, phase 0, cnt 0, esc_trig_o=1 next cycle. This takes priority over timeout.
  - Else if en_i & timeout_en_i & timeout_cyc_i!=0, go to Timeout, cnt 0.
- Timeout: cnt increments each cycle.
  - accu_trig_i, or cnt >= timeout_cyc_i-1: go to Phase 0, cnt 0, esc_trig pulse.
  - Else if !timeout_en_i or clr_i: go to Idle, cnt 0.
  - Escalation takes priority over clear in the same cycle.
- Phase k:
  - cnt increments. When cnt >= phase_cyc_i[k], cnt goes to 0 and the block advances to k+1.
  - From k=NPhases-1 it enters Terminal instead.
  - Phase k therefore lasts phase_cyc_i[k]+1 cycles (minimum 1).
- Terminal: cnt frozen at 0. Phase index held at NPhases-1. If clr_lock_i is high at entry, locked_o is set and held until reset.
- clr_i: in Phase or Terminal with locked_o=0, go to Idle, cnt 0, phase 0. With locked_o=1, clr_i is ignored.
- en_i deassertion while escalating has no effect.
- FsmError:
  - Entered from any state on accu_fail_i, or on an illegal state encoding.
  - All esc_sig_req_o bits assert regardless of esc_en_i.
  - Exited only by reset. Ignores clr_i.
- esc_sig_req_o[s] = esc_en_i[s] & (state in {Phase, Terminal}) & (esc_map_i[s] == phase). It is combinational from registered state plus config, with no input-to-output path from trigger inputs.
- Counter saturates at all-ones and never wraps.
- esc_map_i values >= NPhases never match; the signal stays low.
- Config changes mid-escalation take effect on the next compare.
- State register uses sparse encoding. Any undefined value decodes to FsmError.

Test Plan:
- Reset, then en=1, accu_trig pulse, phase_cyc={2,3,0,1}, esc_map={0,1,2,3}, esc_en=4'hF:
  - esc_trig pulses 1 cycle after the trigger.
  - sig0 is high for 3 cycles, sig1 for 4, sig2 for 1, sig3 for 2.
  - Then Terminal with sig3 held high.
- timeout_en=1, timeout_cyc=5, no accu_trig: Phase 0 entry exactly 5 cycles after the Timeout state. Repeat with timeout_en dropped at cycle 3: returns to Idle, no esc_trig.
- In Phase 1, assert clr_i: Idle next cycle, all esc_sig_req_o=0, esc_cnt_o=0.
- With clr_lock_i=1, reach Terminal: locked_o=1, clr_i is ignored, and the state stays 3 until rst_i is pulsed.
- accu_fail_i in Idle with esc_en=0: state 7, esc_sig_req_o=all ones, clr_i ignored. Asynchronous rst_i mid-cycle clears all outputs immediately.
- Same-cycle accu_trig and clr_i in Timeout: Phase 0 is entered. With en_i=0, an accu_trig pulse in Idle leaves the state Idle.
